// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//   Buffers pixel write requests from the drawing logic and turns them into
//   single-port framebuffer writes, yielding the port to scan-out reads.
//   Also performs a full-frame fill with a latched colour on request.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   pix_valid/pix_ready     pixel request handshake (ready = FIFO not full)
//   pix_x, pix_y, pix_color pixel column, row and RGB444 colour
//   rd_req                  scan-out owns the framebuffer port this cycle
//   fill_start, fill_color  full-frame fill request and its colour
//   fb_we, fb_addr, fb_wdata registered framebuffer write port
//   fill_done               one-cycle pulse after the last fill write
//   drop_cnt                saturating count of out-of-range requests
//   busy                    FIFO non-empty, fill in progress or write pending
module fb_pixel_writer #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int FIFO_DEPTH = 4      // power of 2, at least 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_x,
    input  logic [7:0]  pix_y,
    input  logic [11:0] pix_color,
    input  logic        rd_req,
    input  logic        fill_start,
    input  logic [11:0] fill_color,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [11:0] fb_wdata,
    output logic        fill_done,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [8:0]  H_LIM     = 9'(H_RES);
    localparam logic [8:0]  V_LIM     = 9'(V_RES);
    localparam logic [14:0] FILL_LAST = 15'(H_RES * V_RES - 1);

    typedef enum logic {RUN, FILL} state_t;

    state_t        state;
    logic [27:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [14:0]   fill_cnt;
    logic [11:0]   fill_col;
    logic          fill_last;

    logic          push, pop, in_range;
    logic [7:0]    hx, hy;
    logic [11:0]   hc;
    logic [14:0]   head_addr;

    assign pix_ready = (count != FULL_CNT);
    assign push      = pix_valid && pix_ready;
    assign pop       = (state == RUN) && (count != '0) && !rd_req;

    assign hx        = mem[rd_ptr][27:20];
    assign hy        = mem[rd_ptr][19:12];
    assign hc        = mem[rd_ptr][11:0];
    assign in_range  = ({1'b0, hx} < H_LIM) && ({1'b0, hy} < V_LIM);
    // Constant multiply reduces to shift-and-add (y*160 = (y<<7)+(y<<5));
    // only meaningful for in-range coordinates, which never exceed 15 bits.
    assign head_addr = 15'(hy) * 15'(H_RES) + 15'(hx);

    assign busy      = (count != '0) || (state == FILL) || fb_we;

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {pix_x, pix_y, pix_color};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fill_cnt  <= '0;
            fill_col  <= '0;
            fill_last <= 1'b0;
            fill_done <= 1'b0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_wdata  <= '0;
            drop_cnt  <= '0;
        end else begin
            fb_we     <= 1'b0;
            fill_last <= 1'b0;
            // fill_done trails the last fill write by one cycle
            fill_done <= fill_last;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            case (state)
                RUN: begin
                    if (pop) begin
                        if (in_range) begin
                            fb_we    <= 1'b1;
                            fb_addr  <= head_addr;
                            fb_wdata <= hc;
                        end else if (drop_cnt != '1) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                    if (fill_start) begin
                        state    <= FILL;
                        fill_col <= fill_color;
                        fill_cnt <= '0;
                    end
                end
                FILL: begin
                    if (!rd_req) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= fill_cnt;
                        fb_wdata <= fill_col;
                        if (fill_cnt == FILL_LAST) begin
                            state     <= RUN;
                            fill_last <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [11:0] pix_color;
    logic        rd_req;
    logic        fill_start;
    logic [11:0] fill_color;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_wdata;
    logic        fill_done;
    logic [7:0]  drop_cnt;
    logic        busy;

    int tests  = 0;
    int errors = 0;

    fb_pixel_writer #(.H_RES(160), .V_RES(120), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .rd_req     (rd_req),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fill_done  (fill_done),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // advance past the next rising edge; outputs are stable afterwards
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic v, input int x, input int y, input int c);
        pix_valid = v;
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        pix_color = 12'(c);
    endtask

    initial begin
        int  accepted, exp_addr, seq_err, stall_err;
        bit  done_loop, rd_now;
        logic rdy;

        rst_n = 1'b0; set_pix(1'b0, 0, 0, 0);
        rd_req = 1'b0; fill_start = 1'b0; fill_color = '0;
        #12;
        check("rst_fb_we",    32'(fb_we), 0);
        check("rst_fb_addr",  32'(fb_addr), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_ready",    32'(pix_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // single pixel (5,2) -> 2*160+5 = 325
        set_pix(1'b1, 5, 2, 12'hF00);
        tick();
        set_pix(1'b0, 0, 0, 0);
        check("single_we_early", 32'(fb_we), 0);
        check("single_busy",     32'(busy), 1);
        tick();
        check("single_we",    32'(fb_we), 1);
        check("single_addr",  32'(fb_addr), 325);
        check("single_wdata", 32'(fb_wdata), 32'h0F00);
        tick();
        check("single_we_off",    32'(fb_we), 0);
        check("single_addr_hold", 32'(fb_addr), 325);
        check("single_idle",      32'(busy), 0);

        // six back-to-back pixels while scan-out holds the port
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_pix(1'b1, i, 1, 12'h100 + i);
            rdy = pix_ready;
            tick();
            check($sformatf("bp_ready%0d", i), 32'(rdy), (i < 4) ? 1 : 0);
            check($sformatf("bp_no_we%0d", i), 32'(fb_we), 0);
        end
        set_pix(1'b0, 0, 0, 0);
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain_we%0d", i),    32'(fb_we), 1);
            check($sformatf("drain_addr%0d", i),  32'(fb_addr), 160 + i);
            check($sformatf("drain_wdata%0d", i), 32'(fb_wdata), 32'h100 + i);
            if (i == 0) check("ready_back", 32'(pix_ready), 1);
        end
        tick();
        check("drain_end_we", 32'(fb_we), 0);
        check("drain_drop",   32'(drop_cnt), 0);

        // out-of-range at both boundaries
        set_pix(1'b1, 160, 0, 12'hAAA); tick();
        set_pix(1'b1, 0, 120, 12'hBBB); tick();
        check("oor_we0", 32'(fb_we), 0);
        set_pix(1'b0, 0, 0, 0);
        tick(); check("oor_we1", 32'(fb_we), 0);
        tick(); check("oor_we2", 32'(fb_we), 0);
        check("oor_drop2", 32'(drop_cnt), 2);

        // saturation: 300 more drops
        accepted = 0;
        for (int c = 0; c < 1000 && accepted < 300; c++) begin
            set_pix(1'b1, 200, 7, 12'h0CC);
            rdy = pix_ready;
            tick();
            if (rdy) accepted++;
        end
        set_pix(1'b0, 0, 0, 0);
        check("sat_accepted", 32'(accepted), 300);
        for (int c = 0; c < 6; c++) tick();
        check("sat_drop", 32'(drop_cnt), 255);
        check("sat_idle", 32'(busy), 0);

        // fill with colour 0; a pixel pushed on the same edge lands after the fill
        fill_color = 12'h000;
        fill_start = 1'b1;
        set_pix(1'b1, 3, 4, 12'h123);
        tick();
        fill_start = 1'b0;
        fill_color = 12'hFFF;
        set_pix(1'b0, 0, 0, 0);
        check("fill_busy", 32'(busy), 1);
        exp_addr = 0; seq_err = 0; stall_err = 0; done_loop = 0;
        for (int c = 0; c < 30000 && !done_loop; c++) begin
            rd_req = ((c % 5) == 2) || ((c % 11) == 7);
            // a fill_start during the fill must be ignored
            fill_start = (c == 100);
            rd_now = rd_req;
            tick();
            if (fill_done) seq_err++;
            if (fb_we) begin
                if (rd_now) stall_err++;
                if (fb_addr != 15'(exp_addr) || fb_wdata != 12'h000) seq_err++;
                exp_addr++;
                if (exp_addr == 19200) done_loop = 1;
            end else if (!rd_now) begin
                seq_err++;
            end
        end
        rd_req = 1'b0; fill_start = 1'b0;
        check("fill_count",     32'(exp_addr), 19200);
        check("fill_seq_err",   32'(seq_err), 0);
        check("fill_stall_err", 32'(stall_err), 0);
        check("fill_last_addr", 32'(fb_addr), 19199);
        tick();
        check("fill_done",      32'(fill_done), 1);
        check("post_fill_we",   32'(fb_we), 1);
        check("post_fill_addr", 32'(fb_addr), 643);
        check("post_fill_data", 32'(fb_wdata), 32'h123);
        tick();
        check("fill_done_off",  32'(fill_done), 0);
        check("post_fill_idle", 32'(busy), 0);

        // reset in the middle of a fill with a pixel still queued
        fill_color = 12'h5A5;
        fill_start = 1'b1;
        set_pix(1'b1, 9, 9, 12'h777);
        tick();
        fill_start = 1'b0;
        set_pix(1'b0, 0, 0, 0);
        done_loop = 0;
        for (int c = 0; c < 6000 && !done_loop; c++) begin
            tick();
            if (fb_we && fb_addr == 15'd5000) done_loop = 1;
        end
        check("mid_fill_reached", 32'(done_loop), 1);
        check("mid_fill_wdata",   32'(fb_wdata), 32'h5A5);
        #3 rst_n = 1'b0;
        #1;
        check("arst_we",    32'(fb_we), 0);
        check("arst_addr",  32'(fb_addr), 0);
        check("arst_wdata", 32'(fb_wdata), 0);
        check("arst_busy",  32'(busy), 0);
        check("arst_ready", 32'(pix_ready), 1);
        check("arst_drop",  32'(drop_cnt), 0);
        tick();
        rst_n = 1'b1;
        seq_err = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (fb_we || busy || fill_done) seq_err++;
        end
        check("post_rst_quiet", 32'(seq_err), 0);
        set_pix(1'b1, 159, 119, 12'hFFF);
        tick();
        set_pix(1'b0, 0, 0, 0);
        tick();
        check("corner_we",    32'(fb_we), 1);
        check("corner_addr",  32'(fb_addr), 19199);
        check("corner_wdata", 32'(fb_wdata), 32'hFFF);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 SHALL have parameter H_RES, default 160, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter V_RES, default 120, meaning framebuffer height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning pixel-request buffer entries (power of 2).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 pix_valid  in  1  pixel write request from the drawing-state mux.
REQ-007 pix_ready  out  1  request accepted when pix_valid and pix_ready are both high at a clk edge.
REQ-008 pix_x  in  8  column (CounterX); pix_y  in  8  row (CounterY); pix_color  in  12  RGB444 color.
REQ-009 rd_req  in  1  scan-out read owns the framebuffer port this cycle (priority over writes).
REQ-010 fill_start  in  1  one-cycle pulse requesting a full-frame fill.
REQ-011 fill_color  in  12  color used by fill, sampled on the accepted fill_start edge.
REQ-012 fb_we  out  1  framebuffer write enable; fb_addr  out  15  write address; fb_wdata  out  12  write data.
REQ-013 fill_done  out  1  one-cycle pulse after the last fill write.
REQ-014 drop_cnt  out  8  saturating count of out-of-range requests; busy  out  1  work pending.

Function
REQ-015 FIFO_DEPTH-entry FIFO stores {x,y,color}; pix_ready = FIFO not full; no push while full even if a pop occurs the same edge.
REQ-016 FSM states RUN, FILL; reset state RUN.
REQ-017 RUN: at each edge with FIFO non-empty and rd_req low, pop head; if x<H_RES and y<V_RES register fb_we=1, fb_addr=y*H_RES+x, fb_wdata=color; else fb_we=0 and drop_cnt+1 (saturates at 255).
REQ-018 RUN with rd_req high or FIFO empty: no pop, fb_we=0 next cycle, fb_addr/fb_wdata hold.
REQ-019 Latency: pixel accepted into empty FIFO at edge N, rd_req low -> fb_we high during the cycle following edge N+1; sustained throughput one pixel per clk.
REQ-020 Address arithmetic 15-bit unsigned, y*160 computed as (y<<7)+(y<<5); max in-range address 19199.
REQ-021 fill_start in RUN -> FILL at next edge; FIFO keeps accepting until full, no pops during FILL.
REQ-022 FILL: fill counter 0..H_RES*V_RES-1 advances one per edge with rd_req low, each step fb_we=1, fb_addr=counter, fb_wdata=latched fill_color; rd_req high stalls counter, fb_we=0.
REQ-023 After write at address H_RES*V_RES-1: fill_done high one cycle, return to RUN; FIFO drain resumes next edge.
REQ-024 fill_start during FILL ignored; fill_start and pix_valid same edge: pixel pushed, fill begins, pixel written after fill.
REQ-025 busy = FIFO non-empty or state FILL or fb_we high.

Reset
REQ-026 rst_n low asynchronously: FIFO emptied, state RUN, fill aborted, fb_we=0, fb_addr=0, fb_wdata=0, fill_done=0, drop_cnt=0, busy=0; pix_ready=1 after reset.
REQ-027 Reset mid-fill or mid-drain discards all pending work; no write issued after rst_n rises until a new request.

Verification
REQ-028 Single pixel x=5,y=2,color=0xF00, rd_req low -> fb_we one cycle, fb_addr=325, fb_wdata=0xF00, 2 cycles after accept.
REQ-029 Push 6 back-to-back pixels with rd_req high -> pix_ready low after 4th accept, no fb_we; drop rd_req -> 4 writes in order, ready reasserts.
REQ-030 Pixels (160,0) and (0,120) -> no fb_we, drop_cnt=2; 300 out-of-range pixels -> drop_cnt=255.
REQ-031 fill_start with fill_color=0x000 -> 19200 writes addr 0..19199, fill_done one cycle after addr 19199; rd_req toggled mid-fill stalls without skipping addresses.
REQ-032 rst_n low during fill at counter 5000 -> outputs zero immediately, FIFO empty, no further writes; (159,119) after reset -> fb_addr=19199.
